mul32_seq: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 18 +
 rtl/MUL_32bit.sv | 17 +
 rtl/mul32_seq.sv | 106 ++++++++++
 tb/tb_mul32_seq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared widths and state encoding for the sequential
// 32x32 multiplier controller (mul32_seq) and its 32x8 product stage.
package mul_seq_pkg;

  localparam int OPW   = 32;  // operand width
  localparam int BYTEW = 8;   // multiplier slice consumed per cycle
  localparam int PPW   = 40;  // partial product width (OPW + BYTEW)
  localparam int RESW  = 64;  // full product width
  localparam int STEPS = 4;   // slices per job (OPW / BYTEW)
  localparam int CNTW  = 2;   // slice counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/MUL_32bit.sv
// MUL_32bit: combinational 32x8 unsigned multiplier used as the
// partial-product stage.
//   a_i [31:0]  multiplicand
//   b_i [7:0]   multiplier byte
//   p_o [39:0]  a_i * b_i, exact
module MUL_32bit
  import mul_seq_pkg::*;
(
  input  logic [OPW-1:0]   a_i,
  input  logic [BYTEW-1:0] b_i,
  output logic [PPW-1:0]   p_o
);

  // Both operands zero-extended to the product width so no bits are lost.
  assign p_o = {{BYTEW{1'b0}}, a_i} * {{OPW{1'b0}}, b_i};

endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: multi-cycle 32x32 unsigned multiplier. One byte of B is
// multiplied per cycle through MUL_32bit and shift-accumulated into a
// 64-bit sum; the finished product is published with a one-cycle done.
//   clk      rising-edge clock
//   nrst     asynchronous active-low reset
//   start    job request, accepted in IDLE or DONE
//   A, B     unsigned operands, latched on accept
//   busy     high while the job is running
//   done     one-cycle pulse, Product newly updated
//   Product  last completed result, held until the next completion
module mul32_seq
  import mul_seq_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [OPW-1:0]  A,
  input  logic [OPW-1:0]  B,
  output logic            busy,
  output logic            done,
  output logic [RESW-1:0] Product
);

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [OPW-1:0]    opa_q, opb_q;
  logic [RESW-1:0]   acc_q, acc_d;
  logic [RESW-1:0]   prod_q;
  logic              busy_q, done_q;

  logic [BYTEW-1:0]  b_byte;
  logic [PPW-1:0]    pp;
  logic [RESW-1:0]   pp_sh;

  // Select the multiplier byte for this step.
  always_comb begin
    b_byte = opb_q[BYTEW-1:0];
    case (cnt_q)
      2'd0: b_byte = opb_q[ 7: 0];
      2'd1: b_byte = opb_q[15: 8];
      2'd2: b_byte = opb_q[23:16];
      2'd3: b_byte = opb_q[31:24];
      default: b_byte = opb_q[7:0];
    endcase
  end

  MUL_32bit u_pp (
    .a_i (opa_q),
    .b_i (b_byte),
    .p_o (pp)
  );

  // Partial product weighted by 2^(8*cnt); the sum never exceeds 64 bits.
  assign pp_sh = {{(RESW-PPW){1'b0}}, pp} << {cnt_q, 3'b000};
  assign acc_d = acc_q + pp_sh;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new job exactly like IDLE, giving back-to-back jobs.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= A;
            opb_q   <= B;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(STEPS-1)) begin
            prod_q  <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Product = prod_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq: hand-computed products and cycle timing.
module tb_mul32_seq;

  logic        clk, nrst, start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [63:0] Product;

  int checks = 0;
  int errors = 0;

  mul32_seq dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .Product (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge (edge n); returns at the negedge after edge n.
  task automatic kick(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full job with timing checks: busy for 4 cycles, done exactly once.
  task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    kick(a, b);
    chk({tag, "_busy_n"}, {63'd0, busy}, 64'd1);
    chk({tag, "_done_n"}, {63'd0, done}, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
      chk({tag, "_done_run"}, {63'd0, done}, 64'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    chk({tag, "_prod"}, Product, exp);
    @(negedge clk);
    chk({tag, "_done_clr"}, {63'd0, done}, 64'd0);
    chk({tag, "_prod_hold"}, Product, exp);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; A = '0; B = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", Product, 64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    run_job("small", 32'd3, 32'd5, 64'h0F);
    run_job("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Mid-run start ignored: second request across edge n+2.
    kick(32'h0001_0001, 32'h0102_0304);
    @(negedge clk);               // after n+1
    A = 32'd7; B = 32'd9; start = 1'b1;
    @(negedge clk);               // after n+2
    start = 1'b0;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);               // after n+3
    chk("mid_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);               // after n+4
    chk("mid_done", {63'd0, done}, 64'd1);
    chk("mid_prod", Product, 64'h0000_0102_0406_0304);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_done", {63'd0, done}, 64'd0);
    end
    chk("mid_prod_hold", Product, 64'h0000_0102_0406_0304);

    // Back-to-back: start held high into DONE.
    kick(32'd2, 32'd3);
    repeat (2) @(negedge clk);    // after n+2
    @(negedge clk);               // after n+3
    A = 32'd10; B = 32'd10; start = 1'b1;
    @(negedge clk);               // after n+4
    chk("b2b_done1", {63'd0, done}, 64'd1);
    chk("b2b_prod1", Product, 64'd6);
    @(negedge clk);               // after n+5: accepted from DONE
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_done_clr", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);    // after n+8
    chk("b2b_prod_hold", Product, 64'd6);
    chk("b2b_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);               // after n+9
    chk("b2b_done2", {63'd0, done}, 64'd1);
    chk("b2b_prod2", Product, 64'd100);
    @(negedge clk);

    // Reset mid-run between edges n+2 and n+3.
    kick(32'd5, 32'd7);
    @(negedge clk);               // after n+1
    @(negedge clk);               // after n+2
    nrst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_prod", Product, 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_done", {63'd0, done | busy}, 64'd0);
    end
    run_job("after_rst", 32'd4, 32'd4, 64'd16);

    run_job("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
